// File: rtl/hello_scroll_ctrl_if.sv
// Pattern/control bundle between a pattern driver and hello_scroll_ctrl.
// Latency: none (wires only).
// Backpressure: none; the scroller consumes every input each cycle.
//
// Signals:
//   run        1 = auto-scroll on prescaler terminal count, 0 = prescaler frozen
//   dir        0 = rotate toward HEX7, 1 = rotate toward HEX0
//   step       synchronised level; rising edge = one manual step while run=0
//   load       1 = replace the pattern with load_codes this cycle
//   load_codes new pattern, [23:21] = HEX7 ... [2:0] = HEX0
//   codes      current pattern, registered, same packing as load_codes
//   tick       one-cycle pulse on the first cycle a shifted pattern is visible
interface hello_scroll_ctrl_if;
    logic        run;
    logic        dir;
    logic        step;
    logic        load;
    logic [23:0] load_codes;
    logic [23:0] codes;
    logic        tick;

    modport master (
        output run,
        output dir,
        output step,
        output load,
        output load_codes,
        input  codes,
        input  tick
    );

    modport slave (
        input  run,
        input  dir,
        input  step,
        input  load,
        input  load_codes,
        output codes,
        output tick
    );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// Rotating 8-digit character-code register for the HEX7..HEX0 bank ("HELLO   ").
// Latency: auto shift TICK_DIV cycles after run rises from count 0; manual shift on the step-edge clock.
// Backpressure: none; load wins over any step, step edges while running are dropped.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   io_scroll  slave side of hello_scroll_ctrl_if (run/dir/step/load/load_codes in,
//              codes/tick out)
// Code map per 3-bit digit: 000 H, 001 E, 010 L, 011 O, 100..111 blank.
module hello_scroll_ctrl #(
    parameter int TICK_DIV = 50000000,  // clock cycles per scroll step, >= 2
    parameter int CNT_W    = 26         // prescaler width, 2**CNT_W >= TICK_DIV
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hello_scroll_ctrl_if.slave   io_scroll
);

    // Power-up pattern, HEX7..HEX0 = H E L L O _ _ _
    localparam logic [23:0] LP_RESET_CODES = {3'b000, 3'b001, 3'b010, 3'b010,
                                              3'b011, 3'b100, 3'b100, 3'b100};
    localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_step_q;
    logic [23:0]      r_codes;
    logic             r_tick;

    logic             w_auto_ev;
    logic             w_man_ev;
    logic             w_shift;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [23:0]      w_rot;
    logic [23:0]      w_codes_nxt;
    logic             w_tick_nxt;

    // Terminal count only counts as an event while running; a frozen prescaler
    // parked at TICK_DIV-1 must not keep firing.
    assign w_auto_ev = io_scroll.run && (r_cnt == LP_TERM);

    // Manual edge detector is gated by run so edges during auto-scroll are
    // discarded rather than remembered for later.
    assign w_man_ev  = io_scroll.step && !r_step_q && !io_scroll.run;

    // run and ~run make the two events mutually exclusive; OR is enough.
    assign w_shift   = (w_auto_ev || w_man_ev) && !io_scroll.load;

    // Dir is sampled at the shifting edge itself.
    assign w_rot = io_scroll.dir ? {r_codes[2:0],  r_codes[23:3]}
                                 : {r_codes[20:0], r_codes[23:21]};

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_codes_nxt = r_codes;
        w_tick_nxt  = 1'b0;
        if (io_scroll.load) begin
            // Load restarts the step period and swallows any coincident step.
            w_cnt_nxt   = '0;
            w_codes_nxt = io_scroll.load_codes;
        end else begin
            if (io_scroll.run) begin
                w_cnt_nxt = (r_cnt == LP_TERM) ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_shift) begin
                w_codes_nxt = w_rot;
                w_tick_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_step_q <= 1'b0;
            r_codes  <= LP_RESET_CODES;
            r_tick   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_step_q <= io_scroll.step;  // tracks step unconditionally, even under load
            r_codes  <= w_codes_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    assign io_scroll.codes = r_codes;
    assign io_scroll.tick  = r_tick;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed bench for hello_scroll_ctrl with TICK_DIV=4, digit-array reference model.
// Latency: model mirrors register timing; outputs checked every falling edge.
// Backpressure: not applicable.
module tb_hello_scroll_ctrl;

    localparam int TD = 4;

    logic clk;
    logic rst_n;

    hello_scroll_ctrl_if sif ();

    hello_scroll_ctrl #(.TICK_DIV(TD), .CNT_W(3)) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .io_scroll (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Digits indexed by display position: m_dig[7] = HEX7 ... m_dig[0] = HEX0.
    logic [2:0] m_dig [8];
    int         m_phase;     // run cycles since last load/reset, modulo TD
    bit         m_prev_step;
    bit         m_tick;

    function automatic logic [23:0] m_pack();
        logic [23:0] v;
        for (int i = 0; i < 8; i++) v[3*i +: 3] = m_dig[i];
        return v;
    endfunction

    task automatic m_reset();
        m_dig[7] = 3'd0; m_dig[6] = 3'd1; m_dig[5] = 3'd2; m_dig[4] = 3'd2;
        m_dig[3] = 3'd3; m_dig[2] = 3'd4; m_dig[1] = 3'd4; m_dig[0] = 3'd4;
        m_phase = 0; m_prev_step = 0; m_tick = 0;
    endtask

    task automatic m_clock();
        logic [2:0] old [8];
        bit ev;
        ev = (sif.run && m_phase == TD - 1) || (sif.step && !m_prev_step && !sif.run);
        m_prev_step = sif.step;
        m_tick = 0;
        if (sif.load) begin
            for (int i = 0; i < 8; i++) m_dig[i] = sif.load_codes[3*i +: 3];
            m_phase = 0;
        end else begin
            if (sif.run) m_phase = (m_phase + 1) % TD;
            if (ev) begin
                for (int i = 0; i < 8; i++) old[i] = m_dig[i];
                // left: each digit takes its lower neighbour; right: its upper one
                for (int i = 0; i < 8; i++)
                    m_dig[i] = sif.dir ? old[(i + 1) % 8] : old[(i + 7) % 8];
                m_tick = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_clock();
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("codes_vs_model", sif.codes, m_pack());
            check("tick_vs_model", {23'd0, sif.tick}, {23'd0, m_tick});
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [23:0] HELLO   = 24'b000_001_010_010_011_100_100_100;
    localparam logic [23:0] HELLO_L = 24'b001_010_010_011_100_100_100_000;
    localparam logic [23:0] HELLO_R = 24'b100_000_001_010_010_011_100_100;

    int ticks;
    int first_tick;

    // Run n cycles from the current falling edge, counting Tick pulses.
    task automatic run_cycles(input int n);
        ticks = 0; first_tick = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (sif.tick) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
            end
        end
    endtask

    // Reset pulse placed away from clock edges; leaves bench at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        sif.run = 0; sif.dir = 0; sif.step = 0; sif.load = 0; sif.load_codes = '0;
        #2 rst_n = 0;
        #4 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, expected end", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        sif.run = 0; sif.dir = 0; sif.step = 0; sif.load = 0; sif.load_codes = '0;
        #23 rst_n = 1;
        @(negedge clk);
        cmp_en = 1;

        // 1: reset state
        check("reset_codes", sif.codes, HELLO);
        check("reset_tick", {23'd0, sif.tick}, 24'd0);

        // 2: auto scroll left, 12 cycles -> ticks at 4, 8, 12
        sif.run = 1; sif.dir = 0;
        ticks = 0; first_tick = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sif.tick) begin
                ticks++;
                if (ticks == 1) begin
                    first_tick = k;
                    check("left_after_first_tick", sif.codes, HELLO_L);
                end
                check("tick_spacing", 24'(k), 24'(4 * ticks));
            end
        end
        check("left_tick_count", 24'(ticks), 24'd3);
        check("left_first_tick", 24'(first_tick), 24'd4);

        // 3: auto scroll right from reset, 4 cycles
        do_reset();
        sif.run = 1; sif.dir = 1;
        run_cycles(4);
        check("right_codes", sif.codes, HELLO_R);
        check("right_tick_count", 24'(ticks), 24'd1);

        // 4: manual step held high -> one shift; step pulses while running ignored
        do_reset();
        sif.dir = 0; sif.step = 1;
        run_cycles(10);
        check("manual_tick_count", 24'(ticks), 24'd1);
        check("manual_first_tick", 24'(first_tick), 24'd1);
        check("manual_codes", sif.codes, HELLO_L);
        sif.step = 0;
        @(negedge clk);
        do_reset();
        sif.run = 1;
        ticks = 0;
        for (int k = 1; k <= 8; k++) begin
            sif.step = k[0];
            @(negedge clk);
            if (sif.tick) ticks++;
        end
        check("run_step_ignored", 24'(ticks), 24'd2);
        sif.step = 0; sif.run = 0;
        // manual right step with dir change
        @(negedge clk);
        sif.dir = 1; sif.step = 1;
        @(negedge clk);
        check("manual_right_tick", {23'd0, sif.tick}, 24'd1);
        sif.step = 0;
        @(negedge clk);

        // 5: load on the terminal-count cycle wins and restarts the period
        do_reset();
        sif.run = 1; sif.dir = 0;
        run_cycles(3);
        sif.load = 1; sif.load_codes = 24'hFFFFFF;
        @(negedge clk);
        check("load_codes", sif.codes, 24'hFFFFFF);
        check("load_tick", {23'd0, sif.tick}, 24'd0);
        sif.load = 0;
        run_cycles(4);
        check("post_load_first_tick", 24'(first_tick), 24'd4);

        // 6: pause and resume keeps the count
        do_reset();
        sif.run = 1; sif.dir = 0;
        run_cycles(2);
        sif.run = 0;
        run_cycles(5);
        check("paused_no_tick", 24'(ticks), 24'd0);
        sif.run = 1;
        run_cycles(3);
        check("resume_first_tick", 24'(first_tick), 24'd2);

        // asynchronous reset mid-count, checked before any clock edge
        run_cycles(1);
        #2 rst_n = 0;
        #1;
        check("async_reset_codes", sif.codes, HELLO);
        check("async_reset_tick", {23'd0, sif.tick}, 24'd0);
        #1 rst_n = 1;
        sif.run = 0;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_codes", sif.codes, HELLO);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
